// File: rtl/l2_request_scheduler.sv
// L2 request scheduler: round-robin arbitration across core request ports with a
// bounded-priority fill-restart port, registered single-cycle grant output.
module l2_request_scheduler #(
   parameter int NUM_REQUESTERS    = 4,
   parameter int DATA_WIDTH        = 64,
   parameter int MAX_RESTART_BURST = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQUESTERS-1:0]            req_valid,
   input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQUESTERS-1:0]            req_ready,
   input  logic                                 restart_valid,
   input  logic [DATA_WIDTH-1:0]                restart_data,
   output logic                                 restart_ready,
   input  logic                                 stall,
   output logic                                 out_valid,
   output logic [DATA_WIDTH-1:0]                out_data,
   output logic                                 out_is_restart,
   output logic [$clog2(NUM_REQUESTERS)-1:0]    out_source
);

   localparam int SRC_W = $clog2(NUM_REQUESTERS);

   logic [SRC_W-1:0]      last_grant;
   logic [3:0]            burst_count;
   logic                  any_req;
   logic                  restart_ok;
   logic                  open;
   logic                  restart_grant;
   logic                  core_grant;
   logic                  found;
   logic [SRC_W-1:0]      core_idx;
   logic [DATA_WIDTH-1:0] core_payload;

   // Restart wins unless cores are waiting and the restart burst has used up its quota;
   // the core scan starts just past the last core granted.
   always_comb begin
      any_req       = |req_valid;
      restart_ok    = restart_valid && (!any_req || (burst_count < 4'(MAX_RESTART_BURST)));
      open          = !reset && !stall;
      restart_grant = open && restart_ok;
      found         = 1'b0;
      core_idx      = '0;
      core_payload  = '0;
      for (int i = 1; i <= NUM_REQUESTERS; i++) begin : scan
         int idx;
         idx = (int'(last_grant) + i) % NUM_REQUESTERS;
         if (!found && req_valid[idx]) begin
            found        = 1'b1;
            core_idx     = SRC_W'(idx);
            core_payload = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      core_grant    = open && found && !restart_ok;
      req_ready     = '0;
      if (core_grant) begin
         req_ready[core_idx] = 1'b1;
      end
      restart_ready = restart_grant;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant     <= SRC_W'(NUM_REQUESTERS - 1);
         burst_count    <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_is_restart <= 1'b0;
         out_source     <= '0;
      end else if (!stall) begin
         out_valid <= restart_grant || core_grant;
         if (restart_grant) begin
            out_data       <= restart_data;
            out_is_restart <= 1'b1;
            out_source     <= '0;
            // Only restarts that make cores wait count against the burst quota.
            if (any_req && (burst_count != 4'd15)) begin
               burst_count <= burst_count + 4'd1;
            end
         end else if (core_grant) begin
            out_data       <= core_payload;
            out_is_restart <= 1'b0;
            out_source     <= core_idx;
            last_grant     <= core_idx;
            burst_count    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_l2_request_scheduler.sv
// Scoreboard bench for l2_request_scheduler: directed scenarios then randomized
// traffic, checked against a queue-based behavioural arbitration model.
module tb_l2_request_scheduler;

   localparam int N     = 4;
   localparam int DW    = 64;
   localparam int MRB   = 4;
   localparam int BOUND = N * (MRB + 1);

   logic              clk;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              restart_valid;
   logic [DW-1:0]     restart_data;
   logic              restart_ready;
   logic              stall;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_is_restart;
   logic [1:0]        out_source;

   typedef struct {
      int          kind;
      logic        valid;
      logic [DW-1:0] data;
      logic        is_restart;
      int          src;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;
   int   m_last;
   int   m_burst;
   int   wait_cnt[N];

   l2_request_scheduler #(
      .NUM_REQUESTERS(N),
      .DATA_WIDTH(DW),
      .MAX_RESTART_BURST(MRB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .restart_valid(restart_valid),
      .restart_data(restart_data),
      .restart_ready(restart_ready),
      .stall(stall),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_is_restart(out_is_restart),
      .out_source(out_source)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, expv);
      end
   endtask

   // Reference model: evaluates this cycle's arbitration from the visible inputs,
   // checks the ready strobes and queues the expected next-cycle output.
   task automatic checkOutput();
      exp_t         e;
      logic [N-1:0] exp_rdy;
      logic         exp_rr;
      logic         any;
      int           g;
      e       = '{kind: 2, valid: 1'b0, data: '0, is_restart: 1'b0, src: 0};
      exp_rdy = '0;
      exp_rr  = 1'b0;
      g       = -1;
      any     = (req_valid != '0);
      if (reset) begin
         e.kind  = 0;
         m_last  = N - 1;
         m_burst = 0;
         for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end else if (stall) begin
         e.kind = 1;
         for (int i = 0; i < N; i++) if (!req_valid[i]) wait_cnt[i] = 0;
      end else begin
         if (restart_valid && (!any || m_burst < MRB)) begin
            exp_rr       = 1'b1;
            e.valid      = 1'b1;
            e.data       = restart_data;
            e.is_restart = 1'b1;
            if (any && m_burst < 15) m_burst++;
         end else if (any) begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_last + k) % N;
               if (req_valid[c]) begin
                  g = c;
                  break;
               end
            end
            exp_rdy[g] = 1'b1;
            e.valid    = 1'b1;
            e.data     = req_data[g*DW +: DW];
            e.src      = g;
            m_last     = g;
            m_burst    = 0;
         end
         for (int i = 0; i < N; i++) begin
            if (g == i) begin
               check("wait_bound", 64'(wait_cnt[i] <= BOUND), 64'd1);
               wait_cnt[i] = 0;
            end else if (req_valid[i]) begin
               wait_cnt[i]++;
            end else begin
               wait_cnt[i] = 0;
            end
         end
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("restart_ready", 64'(restart_ready), 64'(exp_rr));
      check("ready_onehot", 64'($countones({req_ready, restart_ready}) <= 1), 64'd1);
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic rst, input logic [N-1:0] rv, input logic rsv,
                                input logic stl, input logic fix_a5);
      @(negedge clk);
      reset         = rst;
      req_valid     = rv;
      restart_valid = rsv;
      stall         = stl;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
      if (fix_a5) req_data[DW +: DW] = 64'hA5;
      restart_data  = {$urandom, $urandom};
      #1;
      checkOutput();
   endtask

   // Monitor: one queued expectation per clock edge, compared just after the edge.
   initial begin
      exp_t        e;
      logic        ev;
      logic [DW-1:0] ed;
      logic        er;
      int          es;
      ev = 1'b0;
      ed = '0;
      er = 1'b0;
      es = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) continue;
         e = exp_q.pop_front();
         if (e.kind == 0) begin
            ev = 1'b0;
            ed = '0;
            er = 1'b0;
            es = 0;
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_out_data", out_data, 64'd0);
            check("reset_out_is_restart", 64'(out_is_restart), 64'd0);
            check("reset_out_source", 64'(out_source), 64'd0);
         end else begin
            if (e.kind == 2) begin
               ev = e.valid;
               if (e.valid) begin
                  ed = e.data;
                  er = e.is_restart;
                  es = e.src;
               end
            end
            check(e.kind == 1 ? "stall_out_valid" : "out_valid", 64'(out_valid), 64'(ev));
            if (ev) begin
               check("out_data", out_data, ed);
               check("out_is_restart", 64'(out_is_restart), 64'(er));
               check("out_source", 64'(out_source), 64'(es));
            end
         end
      end
   end

   initial begin
      logic [N-1:0] seq030[5];
      seq030 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      checks        = 0;
      failures      = 0;
      m_last        = N - 1;
      m_burst       = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      reset         = 1'b1;
      req_valid     = '0;
      req_data      = '0;
      restart_valid = 1'b0;
      restart_data  = '0;
      stall         = 1'b0;

      repeat (3) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Round-robin rotation with every core requesting.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
         check("rr_sequence", 64'(req_ready), 64'(seq030[k]));
      end

      // Restart bursts of MRB interleaved with a single waiting core.
      for (int k = 0; k < 14; k++) begin
         applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
         check("burst_pattern", 64'(restart_ready), 64'((k % 5) != 4));
      end

      // Restart alone is never throttled.
      repeat (20) begin
         applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
         check("restart_only", 64'(restart_ready), 64'd1);
      end

      // Stall holds the output and the pointer.
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
      repeat (3) begin
         applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0);
         check("stall_hold_data", out_data, 64'hA5);
      end
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
      check("after_stall_core2", 64'(req_ready), 64'b0100);

      // Reset mid-burst clears the output and restarts the pointer.
      repeat (3) applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
      check("post_reset_core1", 64'(req_ready), 64'b0010);

      for (int k = 0; k < 10000; k++) begin
         applyStimulus(1'($urandom_range(0, 499) == 0), N'($urandom),
                       1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0), 1'b0);
      end

      repeat (2) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l2_request_scheduler.md
L2_REQUEST_SCHEDULER -- requirements
Module: l2_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, meaning number of core request ports (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning request payload width in bits.
REQ-003 SHALL have parameter MAX_RESTART_BURST, default 4, meaning maximum consecutive restart grants while a core request waits (1..15).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQUESTERS  per-core request pending.
REQ-007 SHALL have port req_data  input  NUM_REQUESTERS*DATA_WIDTH  per-core payload; core i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQUESTERS  per-core accept strobe, combinational.
REQ-009 SHALL have port restart_valid  input  1  fill-restart request pending.
REQ-010 SHALL have port restart_data  input  DATA_WIDTH  restart payload.
REQ-011 SHALL have port restart_ready  output  1  restart accept strobe, combinational.
REQ-012 SHALL have port stall  input  1  downstream pipeline cannot accept.
REQ-013 SHALL have port out_valid  output  1  registered grant valid.
REQ-014 SHALL have port out_data  output  DATA_WIDTH  registered granted payload.
REQ-015 SHALL have port out_is_restart  output  1  registered: granted request came from restart port.
REQ-016 SHALL have port out_source  output  $clog2(NUM_REQUESTERS)  registered core index of grant; 0 when out_is_restart.

Function
REQ-017 SHALL, while stall=1, assert no req_ready or restart_ready bit and hold out_valid, out_data, out_is_restart, out_source, pointer and burst counter unchanged.
REQ-018 SHALL, with stall=0, grant at most one request per cycle; a transfer occurs exactly when the corresponding valid and ready are both 1.
REQ-019 SHALL grant restart when restart_valid=1 and (no req_valid bit set, or burst_count < MAX_RESTART_BURST).
REQ-020 SHALL otherwise, if any req_valid bit is set, grant the first set bit scanning from (last_grant+1) mod NUM_REQUESTERS upward with wrap-around.
REQ-021 SHALL update last_grant to the granted core index on a core grant only; restart grants leave it unchanged.
REQ-022 SHALL increment burst_count (4-bit, saturating at 15) on a restart grant while any req_valid bit is set, clear it on any core grant, and leave it unchanged otherwise.
REQ-023 SHALL, in the cycle after a grant with stall=0, present out_valid=1 with the granted payload and source (one-cycle latency).
REQ-024 SHALL, in the cycle after a non-stalled cycle with no grant, present out_valid=0; out_data/out_source need not change.
REQ-025 SHALL never assert more than one of req_ready/restart_ready bits in the same cycle.
REQ-026 SHALL not depend on req_data/restart_data for ready generation; ready depends only on valid bits, stall, pointer and burst_count.

Reset
REQ-027 SHALL, while reset=1, drive out_valid=0, out_is_restart=0, out_source=0, out_data=0, and all ready outputs to 0.
REQ-028 SHALL set last_grant=NUM_REQUESTERS-1 and burst_count=0 on reset, so the first core grant after reset goes to the lowest-index valid core.
REQ-029 SHALL give reset priority over stall and any pending request; a request presented during reset is not accepted.

Verification
REQ-030 SHALL be verified: after reset, req_valid=4'b1111 held, stall=0 -> req_ready sequence 0001,0010,0100,1000,0001; out_source 0,1,2,3,0 one cycle later each.
REQ-031 SHALL be verified: req_valid=4'b0100 and restart_valid=1 held, MAX_RESTART_BURST=4 -> restart granted 4 cycles, core 2 granted 5th cycle, then restart 4 more.
REQ-032 SHALL be verified: restart_valid=1 only, 20 cycles -> restart granted every cycle, burst_count stays 0, out_is_restart=1, out_source=0.
REQ-033 SHALL be verified: core 1 granted (out_data=0xA5), stall=1 for 3 cycles with req_valid=4'b1111 -> no ready, out_valid=1 and out_data=0xA5 held; after release core 2 granted next.
REQ-034 SHALL be verified: reset asserted mid-stream with out_valid=1 and burst_count=3 -> next cycle out_valid=0, no ready; after release req_valid=4'b1010 grants core 1 first.
REQ-035 SHALL be verified: random valid/stall stimulus 10k cycles -> at most one ready per cycle, every accepted payload appears exactly once on out_data in order, no core waits more than NUM_REQUESTERS*(MAX_RESTART_BURST+1) non-stalled cycles.
